// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: tag layout, unit-type codes,
// op encodings, the queued-instruction record and tag comparison helpers.
// Tag format: {valid, mem, add, mul, 1'b0, id[2:0]}.
package tomasulo_pkg;

   localparam int TAG_W     = 8;
   localparam int TAG_VALID = 7;
   localparam int DATA_W    = 32;
   localparam int REG_AW    = 5;

   // Unit-type field, tag bits [6:4] = {mem, add, mul}
   localparam logic [2:0] TAG_MEM = 3'b100;
   localparam logic [2:0] TAG_ADD = 3'b010;
   localparam logic [2:0] TAG_MUL = 3'b001;

   typedef enum logic [1:0] {
      OP_ADD     = 2'b00,
      OP_MUL     = 2'b01,
      OP_MEM     = 2'b10,
      OP_ILLEGAL = 2'b11
   } op_e;

   typedef struct packed {
      op_e               op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } instr_t;

   localparam int INSTR_W = $bits(instr_t);

   // A broadcast only counts when its valid bit is set; an idle CDB (tag 0)
   // must never match a register whose tag is also 0.
   function automatic logic tag_match(input logic [TAG_W-1:0] reg_tag,
                                      input logic [TAG_W-1:0] cdb_tag);
      return cdb_tag[TAG_VALID] && (reg_tag == cdb_tag);
   endfunction

   // Station select in the same {mem, add, mul} order as the tag unit field.
   function automatic logic [2:0] op_unit(input op_e op);
      case (op)
         OP_ADD:  op_unit = TAG_ADD;
         OP_MUL:  op_unit = TAG_MUL;
         OP_MEM:  op_unit = TAG_MEM;
         default: op_unit = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word-fall-through read (rdata shows the head).
// Ports: clk, reset (sync, active-low), push/wdata, pop/rdata,
//        full, empty, count (0..DEPTH).
// Push while full and pop while empty are ignored. DEPTH must be a power of two.
module sync_fifo #(
   parameter  int WIDTH = 17,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dispatch_regfile.sv
// In-order issue stage and tagged register file.
// Ports:
//   clk, reset (sync, active-low), en (global enable)
//   instr_valid/instr_ready/instr_op/instr_rd/instr_rs1/instr_rs2 : decoder side
//   {add,mul,mem}_ready_for_instr, {add,mul,mem}_acceptor_tag     : station handshake
//   src_in_1/src_in_2, src_in1_type/src_in2_type                 : operands (0 data, 1 tag)
//   {add,mul,mem}_src_valid                                      : one-hot dispatch strobe
//   data_in_CDB/tag_in_CDB                                       : result broadcast
//   init_wr_en/init_wr_addr/init_wr_data                         : preload
//   dbg_addr/dbg_value/dbg_tag                                   : debug read
//   illegal_op                                                   : op-11 entry dropped
module dispatch_regfile
   import tomasulo_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [REG_AW-1:0] instr_rs1,
   input  logic [REG_AW-1:0] instr_rs2,
   input  logic              add_ready_for_instr,
   input  logic              mul_ready_for_instr,
   input  logic              mem_ready_for_instr,
   input  logic [TAG_W-1:0]  add_acceptor_tag,
   input  logic [TAG_W-1:0]  mul_acceptor_tag,
   input  logic [TAG_W-1:0]  mem_acceptor_tag,
   output logic [DATA_W-1:0] src_in_1,
   output logic [DATA_W-1:0] src_in_2,
   output logic              src_in1_type,
   output logic              src_in2_type,
   output logic              add_src_valid,
   output logic              mul_src_valid,
   output logic              mem_src_valid,
   input  logic [DATA_W-1:0] data_in_CDB,
   input  logic [TAG_W-1:0]  tag_in_CDB,
   input  logic              init_wr_en,
   input  logic [REG_AW-1:0] init_wr_addr,
   input  logic [DATA_W-1:0] init_wr_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_value,
   output logic [TAG_W-1:0]  dbg_tag,
   output logic              illegal_op
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_W-1:0]  reg_value [NUM_REGS];
   logic [TAG_W-1:0]   reg_tag   [NUM_REGS];

   logic [INSTR_W-1:0] head_bits;
   instr_t             head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               push;
   logic               pop;
   logic               head_valid;
   logic               head_illegal;
   logic               rename;
   logic [2:0]         unit;
   logic [2:0]         ready_vec;
   logic [2:0]         strobe_vec;
   logic [TAG_W-1:0]   rename_tag;

   assign push = en && instr_valid && !fifo_full;

   sync_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({instr_op, instr_rd, instr_rs1, instr_rs2}),
      .pop   (pop),
      .rdata (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) assert (fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));
   end

   assign head         = instr_t'(head_bits);
   assign instr_ready  = !fifo_full;
   assign head_valid   = en && !fifo_empty;
   assign unit         = op_unit(head.op);
   assign ready_vec    = {mem_ready_for_instr, add_ready_for_instr, mul_ready_for_instr};
   assign strobe_vec   = head_valid ? (unit & ready_vec) : 3'b000;
   assign head_illegal = head_valid && (head.op == OP_ILLEGAL);
   assign pop          = (|strobe_vec) || head_illegal;
   assign rename       = (|strobe_vec) && (head.rd != '0);
   assign illegal_op   = head_illegal;

   assign {mem_src_valid, add_src_valid, mul_src_valid} = strobe_vec;

   always_comb begin
      rename_tag = '0;
      if (strobe_vec[2])      rename_tag = mem_acceptor_tag;
      else if (strobe_vec[1]) rename_tag = add_acceptor_tag;
      else if (strobe_vec[0]) rename_tag = mul_acceptor_tag;
   end

   // Returns {type, operand}. A matching broadcast this cycle is forwarded
   // because the station latches the operand on the same edge the CDB retires.
   function automatic logic [DATA_W:0] read_operand(input logic [REG_AW-1:0] rs,
                                                    input logic [DATA_W-1:0] value,
                                                    input logic [TAG_W-1:0]  tag,
                                                    input logic [TAG_W-1:0]  cdb_tag,
                                                    input logic [DATA_W-1:0] cdb_data);
      if (rs == '0 || !tag[TAG_VALID]) return {1'b0, value};
      else if (tag_match(tag, cdb_tag)) return {1'b0, cdb_data};
      else return {1'b1, {(DATA_W-TAG_W){1'b0}}, tag};
   endfunction

   always_comb begin
      src_in_1     = '0;
      src_in_2     = '0;
      src_in1_type = 1'b0;
      src_in2_type = 1'b0;
      if (head_valid) begin
         {src_in1_type, src_in_1} = read_operand(head.rs1, reg_value[head.rs1],
                                                 reg_tag[head.rs1], tag_in_CDB, data_in_CDB);
         {src_in2_type, src_in_2} = read_operand(head.rs2, reg_value[head.rs2],
                                                 reg_tag[head.rs2], tag_in_CDB, data_in_CDB);
      end
   end

   // Per register: CDB retire beats preload, rename overrides the tag last.
   // R0 is never written after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_value[i] <= '0;
            reg_tag[i]   <= '0;
         end
      end else if (en) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (tag_match(reg_tag[i], tag_in_CDB)) begin
               reg_value[i] <= data_in_CDB;
               reg_tag[i]   <= '0;
            end else if (init_wr_en && init_wr_addr == REG_AW'(i)) begin
               reg_value[i] <= init_wr_data;
               reg_tag[i]   <= '0;
            end
            if (rename && head.rd == REG_AW'(i)) reg_tag[i] <= rename_tag;
         end
      end
   end

   assign dbg_value = reg_value[dbg_addr];
   assign dbg_tag   = reg_tag[dbg_addr];

endmodule

// File: doc/dispatch_regfile.md
Name: dispatch_regfile

Overview:
- In-order issue stage and tagged register file for the Tomasulo core.
- Buffers decoded instructions in a small FIFO. Reads the source operands of the head instruction as either data or a producer tag. Routes the head to the add, mul or mem reservation station using that station's ready/acceptor_tag handshake.
- Renames the destination register to the accepting station's tag.
- Snoops the CDB to retire tags into register values, and forwards a same-cycle CDB broadcast into the operands being dispatched.

Parameters:
- NUM_REGS, 32, architectural registers; R0 is hardwired zero.
- FIFO_DEPTH, 4, instruction queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- en  in  1  global enable; when low, no state change and all *_src_valid are 0.
- instr_valid  in  1  decoder offers an instruction.
- instr_ready  out  1  = queue not full.
- instr_op  in  2  00 add, 01 mul, 10 mem, 11 illegal.
- instr_rd / instr_rs1 / instr_rs2  in  5 each  register indices.
- add_ready_for_instr / mul_ready_for_instr / mem_ready_for_instr  in  1 each  station has a free slot.
- add_acceptor_tag / mul_acceptor_tag / mem_acceptor_tag  in  8 each  tag of the slot that will accept.
- src_in_1 / src_in_2  out  32 each  operand data, or tag in bits [7:0] with upper bits 0.
- src_in1_type / src_in2_type  out  1 each  0 = data, 1 = tag.
- add_src_valid / mul_src_valid / mem_src_valid  out  1 each  one-hot dispatch strobe.
- data_in_CDB  in  32  CDB data.
- tag_in_CDB  in  8  CDB tag; bit7 = valid.
- init_wr_en  in  1  bench/boot preload.
- init_wr_addr  in  5  preload register index.
- init_wr_data  in  32  preload value.
- dbg_addr  in  5  debug read index.
- dbg_value  out  32  combinational read of the register value.
- dbg_tag  out  8  combinational read of the register tag.
- illegal_op  out  1  pulses when an op-11 entry is dropped.

Behaviour:
- Tag format: {valid, mem, add, mul, 1'b0, id[2:0]}.
  - A register is "pending" when tag[7] = 1.
- Reset (reset == 0 at posedge):
  - All register values and tags are 0.
  - FIFO is empty and count is 0.
  - All outputs are 0 except instr_ready, which is 1.
- Push: when en && instr_valid && instr_ready, the instruction is enqueued at posedge.
  - Push and pop may occur in the same cycle; count is then unchanged.
- Head dispatch is combinational within one cycle. With en, FIFO non-empty, and the head op's station ready:
  - Assert that station's *_src_valid.
  - Pop the head at posedge.
  - If the station is not ready, the head stalls and nothing is popped. No reordering.
- Operand read, per source:
  - R0, or register not pending: type 0, data = value.
  - Pending, and tag_in_CDB[7] && tag_in_CDB == reg tag this cycle: bypass, type 0, data = data_in_CDB. This is mandatory because the station latches the operand at the same edge as the one-cycle broadcast.
  - Otherwise: type 1, src = {24'h0, tag}.
- Rename: on dispatch with rd != 0, rd.tag <= acceptor_tag of the selected station.
  - Source reads use the pre-rename state, so rd == rs1 reads the old producer.
- CDB retire: every register with a tag equal to a valid tag_in_CDB gets value <= data_in_CDB and tag <= 0, in the same edge.
  - Multiple registers may match and all retire.
- Simultaneous CDB retire and rename of the same register: rename wins for the tag; the value takes the CDB data.
- init_wr_en: value <= data and tag <= 0.
  - Lowest priority against rename and CDB on the same register.
  - Ignored for R0.
- Illegal op at head: popped without a strobe; illegal_op = 1 for that cycle.
- When FIFO is empty, all strobes are 0 and src/type outputs are 0.
- Reset mid-stall discards queued instructions and all pending tags.

Decomposition:
- Shared package tomasulo_pkg holds:
  - tag field positions and unit-type constants (TAG_ADD = 3'b010 etc.);
  - op encodings;
  - a tag_match function shared with the reservation stations.
- Sub-module sync_fifo: parameterised width and depth, push/pop/full/empty/count. Instantiated once with width 17 (op + 3 indices).

Test Plan:
1. Reset, then preload R1 = 5 and R2 = 7; dbg on R1..R31 → R1 = 5, R2 = 7, all others 0 with tag 0; instr_ready = 1.
2. Push add r3 = r1 + r2 with add_acceptor_tag = 0xA2 and ready = 1 → add_src_valid = 1, src_in_1 = 5, src_in_2 = 7, types 0; next cycle dbg R3 tag = 0xA2.
3. Push add r4 = r3 + r1 → src_in_1 = 0x000000A2, src_in1_type = 1, src_in_2 = 5.
   - Then CDB tag 0xA2, data 0x0C → R3 = 0x0C, tag 0.
4. Bypass: head reads pending r3 (tag 0xA2) while CDB broadcasts 0xA2 / 0x0C in the same cycle → src_in1_type = 0, src_in_1 = 0x0C.
5. Stall: add_ready_for_instr = 0, push 4 adds → no strobes, instr_ready = 0 after the 4th push. Then set ready = 1 → one strobe per cycle for 4 cycles, in push order, and instr_ready returns to 1.
6. Collision: dispatch mul r5 (tag 0x91) in the same cycle as CDB retiring r5's old tag with data 9 → R5 tag = 0x91, value = 9. Also push op 11 → illegal_op pulses once and no strobe.
